z80_cmd_nmi_ctrl: RTL

- Z80-side companion to the 68K/Z80 sound-command latch block.
- Decodes Z80 I/O cycles into the latch strobes nSDZ80R, nSDZ80W and nSDZ80CLR.
- Synchronises the 68K command-write strobe nSDW into the Z80 clock domain and generates a timed NMI pulse to the Z80.
- Tracks pending/overrun status and gates the NMI with a software enable.

---
 rtl/z80_cmd_nmi_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/z80_cmd_nmi_ctrl.sv
`timescale 1ns/1ps
// z80_cmd_nmi_ctrl: Z80-side I/O strobe decode, command sync, status tracking and NMI pulse generation
module z80_cmd_nmi_ctrl #(
   parameter int NMI_WIDTH = 4,
   parameter int CNT_W     = 8
) (
   input  logic             CLK_4M,
   input  logic             nRESET,
   input  logic             nSDW,
   input  logic [4:0]       SDA_L,
   input  logic             nIORQ,
   input  logic             nRD,
   input  logic             nWR,
   input  logic             nM1,
   output logic             nSDZ80R,
   output logic             nSDZ80W,
   output logic             nSDZ80CLR,
   output logic             nNMI,
   output logic             NMI_EN,
   output logic             PENDING,
   output logic             OVERRUN,
   output logic [CNT_W-1:0] CMD_COUNT
);
   typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;
   localparam logic [3:0] WIDTH = 4'(NMI_WIDTH);
   logic rs1_q, rst_n_q;
   logic s1_q, s2_q, prev_q, rdn_q;
   logic nmi_en_q, nmi_en_d;
   logic pending_q, pending_d;
   logic overrun_q, overrun_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t state_q;
   logic [3:0] pcnt_q;
   logic nnmi_q;
   logic io, cmd_evt, rd_done;
   // Reset asserts asynchronously and releases after two clean clock edges
   always_ff @(posedge CLK_4M or negedge nRESET)
      if (!nRESET) begin
         rs1_q   <= 1'b0;
         rst_n_q <= 1'b0;
      end else begin
         rs1_q   <= 1'b1;
         rst_n_q <= rs1_q;
      end
   // Bus decode is combinational because the latch data path is asynchronous; status next-state follows
   always_comb begin
      io        = !nIORQ & nM1;
      nSDZ80R   = !(io & !nRD & SDA_L == 5'h00);
      nSDZ80CLR = !(io & !nWR & SDA_L == 5'h00);
      nSDZ80W   = !(io & !nWR & SDA_L == 5'h0C);
      cmd_evt   = prev_q & !s2_q;
      rd_done   = !rdn_q & nSDZ80R;
      nmi_en_d  = (io & !nWR & SDA_L == 5'h08) ? 1'b1 :
                  (io & !nWR & SDA_L == 5'h18) ? 1'b0 : nmi_en_q;
      pending_d = cmd_evt ? 1'b1 : rd_done ? 1'b0 : pending_q;
      overrun_d = !nSDZ80CLR ? 1'b0 : (cmd_evt & pending_q & !rd_done) ? 1'b1 : overrun_q;
      cnt_d     = cnt_q + CNT_W'(cmd_evt);
   end
   // Synchroniser, read-strobe history and status registers
   always_ff @(posedge CLK_4M or negedge rst_n_q)
      if (!rst_n_q) begin
         s1_q      <= 1'b1;
         s2_q      <= 1'b1;
         prev_q    <= 1'b1;
         rdn_q     <= 1'b1;
         nmi_en_q  <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= nSDW;
         s2_q      <= s1_q;
         prev_q    <= s2_q;
         rdn_q     <= nSDZ80R;
         nmi_en_q  <= nmi_en_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         cnt_q     <= cnt_d;
      end
   // NMI pulse FSM with a registered, glitch-free nNMI
   always_ff @(posedge CLK_4M or negedge rst_n_q)
      if (!rst_n_q) begin
         state_q <= IDLE;
         pcnt_q  <= '0;
         nnmi_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE:
               if (pending_q & nmi_en_q) begin
                  state_q <= PULSE;
                  pcnt_q  <= WIDTH;
                  nnmi_q  <= 1'b0;
               end
            PULSE:
               if (pcnt_q <= 4'd1) begin
                  state_q <= WAIT;
                  pcnt_q  <= '0;
                  nnmi_q  <= 1'b1;
               end else begin
                  pcnt_q <= pcnt_q - 4'd1;
               end
            WAIT:
               if (!pending_q | cmd_evt) state_q <= IDLE;
            default: begin
               state_q <= IDLE;
               nnmi_q  <= 1'b1;
            end
         endcase
      end
   assign nNMI      = nnmi_q;
   assign NMI_EN    = nmi_en_q;
   assign PENDING   = pending_q;
   assign OVERRUN   = overrun_q;
   assign CMD_COUNT = cnt_q;
endmodule
